// File: rtl/keypad_scanner.sv
// 5x5 matrix keypad scanner: row scan, 2-flop column synchroniser, press/release debounce, and
// decode of each accepted key into a one-cycle event. Define KEYPAD_REPEAT_EN for hex auto-repeat.
module keypad_scanner #(
  parameter int SETTLE_CYCLES   = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] col_n,
  output logic [4:0] row_n,
  output logic       newhex,
  output logic [3:0] hexcode,
  output logic       newop,
  output logic [1:0] opcode,
  output logic       eq,
  output logic       clr,
  output logic       key_held
);

  localparam int CNT_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {SCAN, DEBOUNCE, EMIT, HELD, RELEASE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       row_q, row_d;
  logic [2:0]       col_q, col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       col_m, col_s;
  logic [2:0]       low_col;
  logic             any_low, key_seen, col_up, row_live;
  logic             is_hex, is_op, is_eq, is_clr;
  logic             rep_fire;

  always_ff @(posedge clock) begin
    if (reset) begin
      col_m <= '1;
      col_s <= '1;
    end else begin
      col_m <= col_n;
      col_s <= col_m;
    end
  end

  // Lowest-index low column wins when several keys in the driven row are down.
  always_comb begin
    low_col = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (!col_s[i]) low_col = 3'(i);
    end
  end

  assign any_low  = ~&col_s;
  assign key_seen = any_low && !(row_q == 3'd4 && low_col >= 3'd2);
  assign col_up   = col_s[col_q];
  // row_n is all-ones only in the first cycle after reset; settling starts once a row is driven.
  assign row_live = ~&row_n;

  assign is_hex = (row_q < 3'd4) && (col_q < 3'd4);
  assign is_op  = (row_q < 3'd4) && (col_q == 3'd4);
  assign is_eq  = (row_q == 3'd4) && (col_q == 3'd0);
  assign is_clr = (row_q == 3'd4) && (col_q == 3'd1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SCAN;
      row_q   <= 3'd0;
      col_q   <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    case (state_q)
      SCAN: begin
        if (!row_live) begin
          cnt_d = '0;
        end else if (cnt_q != SETTLE_C) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = '0;
          if (key_seen) begin
            state_d = DEBOUNCE;
            col_d   = low_col;
          end else begin
            row_d = (row_q == 3'd4) ? 3'd0 : row_q + 3'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (col_up) begin
          state_d = SCAN;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = EMIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      EMIT: begin
        state_d = HELD;
        cnt_d   = '0;
      end
      HELD: begin
        if (col_up) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
      end
      RELEASE: begin
        if (!col_up) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = SCAN;
          row_d   = 3'd0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = SCAN;
        row_d   = 3'd0;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    newhex   = 1'b0;
    newop    = 1'b0;
    eq       = 1'b0;
    clr      = 1'b0;
    key_held = 1'b0;
    case (state_q)
      EMIT: begin
        newhex   = is_hex;
        newop    = is_op;
        eq       = is_eq;
        clr      = is_clr;
        key_held = 1'b1;
      end
      HELD: begin
        newhex   = rep_fire;
        key_held = 1'b1;
      end
      RELEASE: key_held = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      row_n <= '1;
    end else begin
      row_n <= ~(5'd1 << row_d);
    end
  end

  // Codes load on the edge into EMIT so they are already valid while the pulse is high.
  always_ff @(posedge clock) begin
    if (reset) begin
      hexcode <= 4'h0;
      opcode  <= 2'd0;
    end else if (state_d == EMIT) begin
      if (is_hex) hexcode <= {row_q[1:0], col_q[1:0]};
      if (is_op)  opcode  <= row_q[1:0];
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DELAY_C  = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_PERIOD_C = REP_W'(REPEAT_PERIOD);
  localparam logic [REP_W-1:0] REP_TOP      = REP_W'(REP_MAX);
  localparam logic [REP_W-1:0] REP_ONE      = REP_W'(1);

  logic [REP_W-1:0] rep_cnt_q;
  logic             rep_first_q;

  assign rep_fire = (state_q == HELD) && is_hex && !col_up &&
                    (rep_cnt_q == (rep_first_q ? REP_DELAY_C : REP_PERIOD_C));

  // Counts cycles since EMIT or the last repeat; frozen in RELEASE so a bounce resumes the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else if (state_q == EMIT) begin
      rep_cnt_q   <= REP_ONE;
      rep_first_q <= 1'b1;
    end else if (rep_fire) begin
      rep_cnt_q   <= REP_ONE;
      rep_first_q <= 1'b0;
    end else if (state_q == HELD && is_hex && rep_cnt_q != REP_TOP) begin
      rep_cnt_q <= rep_cnt_q + REP_ONE;
    end
  end
`else
  logic unused_rep_params;
  assign unused_rep_params = (REPEAT_DELAY != 0) ^ (REPEAT_PERIOD != 0);
  assign rep_fire = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SETTLE_CYCLES=2, DEBOUNCE_CYCLES=8); a keypad model closes
// driven rows onto col_n and a monitor logs every pulse as {kind, code, cycle since reset}.
module tb_keypad_scanner;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] col_n;
  logic [4:0] row_n;
  logic       newhex, newop, eq, clr, key_held;
  logic [3:0] hexcode;
  logic [1:0] opcode;

  logic [4:0]  key_down [5];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          n_multi = 0;
  int          base = 0;
  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] got;

  keypad_scanner #(
    .SETTLE_CYCLES(2), .DEBOUNCE_CYCLES(8), .REPEAT_DELAY(20), .REPEAT_PERIOD(10)
  ) dut (
    .clock(clock), .reset(reset), .col_n(col_n), .row_n(row_n),
    .newhex(newhex), .hexcode(hexcode), .newop(newop), .opcode(opcode),
    .eq(eq), .clr(clr), .key_held(key_held)
  );

  // ---- clock / reset / keypad model ----
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

  always_comb begin
    col_n = 5'b11111;
    for (int r = 0; r < 5; r++) begin
      if (!row_n[r]) col_n = col_n & ~key_down[r];
    end
  end

  // kind: 1 = hex, 2 = op, 3 = eq, 4 = clr
  always @(negedge clock) begin
    if (!reset) begin
      if (newhex) obs_q.push_back({4'd1, hexcode, cyc[7:0]});
      if (newop)  obs_q.push_back({4'd2, 2'b00, opcode, cyc[7:0]});
      if (eq)     obs_q.push_back({4'd3, 4'd0, cyc[7:0]});
      if (clr)    obs_q.push_back({4'd4, 4'd0, cyc[7:0]});
      if (int'(newhex) + int'(newop) + int'(eq) + int'(clr) > 1) n_multi++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---- driver tasks ----
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    base = obs_q.size();
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clock);
  endtask

  task automatic clear_keys();
    for (int r = 0; r < 5; r++) key_down[r] = 5'b00000;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    clear_keys();
    do_reset();
    checks++; if (row_n !== 5'b11111) begin errors++; $display("FAIL reset_row_n: got %b want 11111", row_n); end
    checks++; if ({newhex, newop, eq, clr} !== 4'b0000) begin errors++; $display("FAIL reset_pulses: got %b want 0000", {newhex, newop, eq, clr}); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_key_held: got %b want 0", key_held); end
    checks++; if (hexcode !== 4'h0) begin errors++; $display("FAIL reset_hexcode: got %h want 0", hexcode); end
    checks++; if (opcode !== 2'd0) begin errors++; $display("FAIL reset_opcode: got %0d want 0", opcode); end
    wait_cyc(1);
    checks++; if (row_n !== 5'b11110) begin errors++; $display("FAIL scan_row0: got %b want 11110", row_n); end
    wait_cyc(4);
    checks++; if (row_n !== 5'b11101) begin errors++; $display("FAIL scan_row1: got %b want 11101", row_n); end
    wait_cyc(7);
    checks++; if (row_n !== 5'b11011) begin errors++; $display("FAIL scan_row2: got %b want 11011", row_n); end
  endtask

  // r2c1 held from reset: row 2 sampled at cycle 9, pulse at 9+8+1 = 18.
  task automatic test_hex_press();
    clear_keys();
    key_down[2] = 5'b00010;
    do_reset();
    wait_cyc(17);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL hex_held_before: got %b want 0", key_held); end
    wait_cyc(18);
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL hex_held_at_emit: got %b want 1", key_held); end
    wait_cyc(30);
    checks++; if (row_n !== 5'b11011) begin errors++; $display("FAIL hex_row_hold: got %b want 11011", row_n); end
    wait_cyc(58);
    key_down[2] = 5'b00000;
    // release seen by col_s at 60, RELEASE 61..68, back to SCAN row 0 at 69
    wait_cyc(68);
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL hex_held_release: got %b want 1", key_held); end
    wait_cyc(69);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL hex_held_after: got %b want 0", key_held); end
    checks++; if (row_n !== 5'b11110) begin errors++; $display("FAIL hex_rescan_row: got %b want 11110", row_n); end
    checks++; if (hexcode !== 4'h9) begin errors++; $display("FAIL hex_code_hold: got %h want 9", hexcode); end
    exp_q.delete();
    exp_q.push_back({4'd1, 4'h9, 8'd18});
    checks++; if (obs_q.size() - base != exp_q.size()) begin errors++; $display("FAIL hex_count: got %0d want %0d", obs_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base + i < obs_q.size()) ? obs_q[base + i] : 16'hxxxx;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL hex_event%0d: got %h want %h", i, got, exp_q[i]); end
    end
  endtask

  // r1c4 bounces 3 on / 3 off three times from cycle 4, stable from 22; final sample 24, pulse 33.
  task automatic test_bounce();
    clear_keys();
    do_reset();
    wait_cyc(4);  key_down[1] = 5'b10000;
    wait_cyc(7);  key_down[1] = 5'b00000;
    wait_cyc(10); key_down[1] = 5'b10000;
    wait_cyc(13); key_down[1] = 5'b00000;
    wait_cyc(16); key_down[1] = 5'b10000;
    wait_cyc(19); key_down[1] = 5'b00000;
    wait_cyc(22); key_down[1] = 5'b10000;
    wait_cyc(45); key_down[1] = 5'b00000;
    wait_cyc(70);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL bounce_held_after: got %b want 0", key_held); end
    checks++; if (opcode !== 2'd1) begin errors++; $display("FAIL bounce_opcode: got %0d want 1", opcode); end
    exp_q.delete();
    exp_q.push_back({4'd2, 4'd1, 8'd33});
    checks++; if (obs_q.size() - base != exp_q.size()) begin errors++; $display("FAIL bounce_count: got %0d want %0d", obs_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base + i < obs_q.size()) ? obs_q[base + i] : 16'hxxxx;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL bounce_event%0d: got %h want %h", i, got, exp_q[i]); end
    end
  endtask

  // r4c0 from reset -> eq at 24; r4c1 added at 30 is ignored; new r4c1 press at 60 -> clr at 74.
  task automatic test_eq_clr();
    clear_keys();
    key_down[4] = 5'b00001;
    do_reset();
    wait_cyc(30); key_down[4] = 5'b00011;
    wait_cyc(35);
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL eqclr_held: got %b want 1", key_held); end
    wait_cyc(40); key_down[4] = 5'b00000;
    wait_cyc(60);
    checks++; if (obs_q.size() - base != 1) begin errors++; $display("FAIL eqclr_count_mid: got %0d want 1", obs_q.size() - base); end
    key_down[4] = 5'b00010;
    wait_cyc(80); key_down[4] = 5'b00000;
    wait_cyc(100);
    exp_q.delete();
    exp_q.push_back({4'd3, 4'd0, 8'd24});
    exp_q.push_back({4'd4, 4'd0, 8'd74});
    checks++; if (obs_q.size() - base != exp_q.size()) begin errors++; $display("FAIL eqclr_count: got %0d want %0d", obs_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base + i < obs_q.size()) ? obs_q[base + i] : 16'hxxxx;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL eqclr_event%0d: got %h want %h", i, got, exp_q[i]); end
    end
  endtask

  // r0c0 closed for cycles 1..5 only: debounce aborts at 8, scanning resumes at row 0 from 9.
  task automatic test_short_press();
    clear_keys();
    key_down[0] = 5'b00001;
    do_reset();
    wait_cyc(6); key_down[0] = 5'b00000;
    wait_cyc(7);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL short_held: got %b want 0", key_held); end
    wait_cyc(13);
    checks++; if (row_n !== 5'b11101) begin errors++; $display("FAIL short_rescan: got %b want 11101", row_n); end
    wait_cyc(40);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL short_held_late: got %b want 0", key_held); end
    checks++; if (obs_q.size() - base != 0) begin errors++; $display("FAIL short_count: got %0d want 0", obs_q.size() - base); end
  endtask

  // r3c3 held: reset during DEBOUNCE (cycle 16) and again in HELD (cycle 25); each restart yields F at 21.
  task automatic test_reset_midway();
    clear_keys();
    key_down[3] = 5'b01000;
    do_reset();
    wait_cyc(16);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL midrst_held_deb: got %b want 0", key_held); end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (row_n !== 5'b11111) begin errors++; $display("FAIL midrst_row_n: got %b want 11111", row_n); end
    checks++; if ({newhex, newop, eq, clr, key_held} !== 5'b00000) begin errors++; $display("FAIL midrst_outs: got %b want 00000", {newhex, newop, eq, clr, key_held}); end
    reset = 1'b0;
    wait_cyc(21);
    checks++; if (hexcode !== 4'hF) begin errors++; $display("FAIL midrst_code: got %h want f", hexcode); end
    wait_cyc(25);
    reset = 1'b1;
    @(negedge clock);
    checks++; if (hexcode !== 4'h0) begin errors++; $display("FAIL midrst_hold_code: got %h want 0", hexcode); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL midrst_hold_held: got %b want 0", key_held); end
    reset = 1'b0;
    wait_cyc(30); key_down[3] = 5'b00000;
    wait_cyc(50);
    exp_q.delete();
    exp_q.push_back({4'd1, 4'hF, 8'd21});
    exp_q.push_back({4'd1, 4'hF, 8'd21});
    checks++; if (obs_q.size() - base != exp_q.size()) begin errors++; $display("FAIL midrst_count: got %0d want %0d", obs_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base + i < obs_q.size()) ? obs_q[base + i] : 16'hxxxx;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL midrst_event%0d: got %h want %h", i, got, exp_q[i]); end
    end
  endtask

`ifdef KEYPAD_REPEAT_EN
  // r0c2 from reset: EMIT at 12, repeats at 32, 42, 52, 62, 72; r2c4 gives one newop at 18.
  task automatic test_repeat();
    clear_keys();
    key_down[0] = 5'b00100;
    do_reset();
    wait_cyc(73); key_down[0] = 5'b00000;
    wait_cyc(100);
    exp_q.delete();
    exp_q.push_back({4'd1, 4'h2, 8'd12});
    for (int k = 0; k < 5; k++) exp_q.push_back({4'd1, 4'h2, 8'(32 + 10 * k)});
    checks++; if (obs_q.size() - base != exp_q.size()) begin errors++; $display("FAIL repeat_count: got %0d want %0d", obs_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base + i < obs_q.size()) ? obs_q[base + i] : 16'hxxxx;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL repeat_event%0d: got %h want %h", i, got, exp_q[i]); end
    end
    clear_keys();
    key_down[2] = 5'b10000;
    do_reset();
    wait_cyc(100); key_down[2] = 5'b00000;
    wait_cyc(120);
    checks++; if (obs_q.size() - base != 1) begin errors++; $display("FAIL repeat_op_count: got %0d want 1", obs_q.size() - base); end
    got = (base < obs_q.size()) ? obs_q[base] : 16'hxxxx;
    checks++; if (got !== {4'd2, 4'd2, 8'd18}) begin errors++; $display("FAIL repeat_op_event: got %h want %h", got, {4'd2, 4'd2, 8'd18}); end
  endtask
`endif

  task automatic test_exclusive();
    checks++; if (n_multi !== 0) begin errors++; $display("FAIL exclusive_pulses: got %0d cycles with >1 pulse want 0", n_multi); end
  endtask

  initial begin
    test_reset();
    test_hex_press();
    test_bounce();
    test_eq_clr();
    test_short_press();
    test_reset_midway();
`ifdef KEYPAD_REPEAT_EN
    test_repeat();
`endif
    test_exclusive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
